key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 5 +
 rtl/sync_2ff.sv | 20 ++
 rtl/key_debounce.sv | 84 ++++++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and default debounce constant for key inputs.
package key_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_FILT, PRESSED, REL_FILT} key_fsm_t;
   localparam int KEY_CNT_MAX_20MS = 1_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, reset to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronized, filtered key level with one-cycle press/release pulses.
// Release pulse enabled by KEY_DEBOUNCE_RELEASE_PULSE_EN; otherwise key_release is tied low.
module key_debounce
   import key_pkg::*;
#(
   parameter int   CNT_MAX     = KEY_CNT_MAX_20MS,
   parameter logic PRESS_LEVEL = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release
);
   localparam int CW = $clog2(CNT_MAX);
   localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
   logic key_sync;
   logic pressed;
   key_fsm_t state;
   logic [CW-1:0] cnt;
   sync_2ff #(.RST_VAL(~PRESS_LEVEL)) u_sync (
      .clk (sys_clk),
      .rst (sys_rst),
      .d   (key_in),
      .q   (key_sync)
   );
   assign pressed = (key_sync == PRESS_LEVEL);
`ifndef KEY_DEBOUNCE_RELEASE_PULSE_EN
   assign key_release = 1'b0;
`endif
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         key_state <= 1'b0;
         key_press <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
         key_release <= 1'b0;
`endif
      end else begin
         key_press <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
         key_release <= 1'b0;
`endif
         case (state)
            IDLE:
               if (pressed) begin
                  state <= PRESS_FILT;
                  cnt   <= '0;
               end
            PRESS_FILT:
               if (!pressed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state     <= PRESSED;
                  key_state <= 1'b1;
                  key_press <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            PRESSED:
               if (!pressed) begin
                  state <= REL_FILT;
                  cnt   <= '0;
               end
            REL_FILT:
               if (pressed) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state     <= IDLE;
                  key_state <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
                  key_release <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
         endcase
      end
   end
endmodule
